// File: rtl/rom_access_arbiter_if.sv
// ROM access bus shared by the CPU port, the auxiliary port and the ROM itself.
// slave  : arbiter view (takes requests and ROM data, drives grants, read data and ROM address)
// master : environment view (CPU, aux requester and ROM model)
// Signals: cpu_req/cpu_addr/cpu_gnt/cpu_rvalid/cpu_rdata,
//          aux_req/aux_addr/aux_gnt/aux_rvalid/aux_rdata, rom_addr, rom_data
interface rom_access_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  cpu_req;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_gnt;
  logic                  cpu_rvalid;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  aux_req;
  logic [ADDR_WIDTH-1:0] aux_addr;
  logic                  aux_gnt;
  logic                  aux_rvalid;
  logic [DATA_WIDTH-1:0] aux_rdata;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;

  modport slave (
    input  cpu_req, cpu_addr, aux_req, aux_addr, rom_data,
    output cpu_gnt, cpu_rvalid, cpu_rdata, aux_gnt, aux_rvalid, aux_rdata, rom_addr
  );

  modport master (
    output cpu_req, cpu_addr, aux_req, aux_addr, rom_data,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, aux_gnt, aux_rvalid, aux_rdata, rom_addr
  );
endinterface

// File: rtl/rom_access_arbiter.sv
// Arbiter for the single-port synchronous-read BASIC ROM shared by the 6502 CPU and an
// auxiliary reader. One read per clock; CPU has priority, but an aux request denied
// STARVE_LIMIT consecutive cycles is forced through on the next cycle.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : rom_access_arbiter_if.slave (requests, grants, read data, ROM address/data)
module rom_access_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  rom_access_arbiter_if.slave bus
);

  logic [3:0]            r_starve_cnt;
  logic                  r_cpu_rvalid;
  logic                  r_aux_rvalid;
  logic                  w_force_aux;
  logic                  w_cpu_gnt;
  logic                  w_aux_gnt;
  logic [ADDR_WIDTH-1:0] w_rom_addr;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Grants are gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    w_force_aux = bus.aux_req && (r_starve_cnt >= 4'(STARVE_LIMIT));
    w_cpu_gnt   = 1'b0;
    w_aux_gnt   = 1'b0;
    if (rst_n) begin
      if (w_force_aux) begin
        w_aux_gnt = 1'b1;
      end else if (bus.cpu_req) begin
        w_cpu_gnt = 1'b1;
      end else if (bus.aux_req) begin
        w_aux_gnt = 1'b1;
      end
    end
  end

  // Idle cycles still present cpu_addr; the resulting ROM read is simply ignored.
  assign w_rom_addr = w_aux_gnt ? bus.aux_addr : bus.cpu_addr;
  assign w_rdata    = bus.rom_data;

  // Counts consecutive denied aux cycles; saturates so it never wraps back under the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 4'd0;
    end else if (bus.aux_req && !w_aux_gnt) begin
      if (r_starve_cnt != 4'd15) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end else begin
      r_starve_cnt <= 4'd0;
    end
  end

  // rvalid mirrors the grant one cycle later, matching the ROM's registered read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_rvalid <= 1'b0;
      r_aux_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid <= w_cpu_gnt;
      r_aux_rvalid <= w_aux_gnt;
    end
  end

  assign bus.cpu_gnt    = w_cpu_gnt;
  assign bus.aux_gnt    = w_aux_gnt;
  assign bus.rom_addr   = w_rom_addr;
  assign bus.cpu_rvalid = r_cpu_rvalid;
  assign bus.aux_rvalid = r_aux_rvalid;
  assign bus.cpu_rdata  = w_rdata;
  assign bus.aux_rdata  = w_rdata;

endmodule

// File: doc/rom_access_arbiter.md
Name: rom_access_arbiter

Overview:
- Shares the single-port, synchronous-read 16 KB BASIC ROM (0x8000-0xBFFF) between two requesters: the 6502 CPU bus (port C) and an auxiliary master (port A), such as the monitor/checksum or debug reader.
- Arbitrates one ROM read per clock and steers the ROM address mux.
- Returns read data to the winning port with a valid strobe that tracks the ROM's one-cycle read latency.
- CPU has priority; a starvation counter guarantees the auxiliary port progress.

Parameters:
- ADDR_WIDTH, 14, ROM address width (16 KB).
- DATA_WIDTH, 8, ROM data width.
- STARVE_LIMIT, 4, consecutive denied aux-request cycles before aux is forced to win (1..15).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cpu_req  input  1  CPU read request, level, one read per cycle held high
- cpu_addr  input  ADDR_WIDTH  CPU ROM offset
- cpu_gnt  output  1  CPU request accepted this cycle (combinational)
- cpu_rvalid  output  1  cpu_rdata valid (registered)
- cpu_rdata  output  DATA_WIDTH  read data to CPU
- aux_req  input  1  auxiliary read request, held until granted
- aux_addr  input  ADDR_WIDTH  auxiliary ROM offset, stable while aux_req high and ungranted
- aux_gnt  output  1  aux request accepted this cycle (combinational)
- aux_rvalid  output  1  aux_rdata valid (registered)
- aux_rdata  output  DATA_WIDTH  read data to aux
- rom_addr  output  ADDR_WIDTH  address to ROM (combinational mux)
- rom_data  input  DATA_WIDTH  ROM data_out (registered inside ROM)

Behaviour:
- Reset (rst_n low, async):
  - cpu_gnt = aux_gnt = 0 (forced even if req high).
  - cpu_rvalid = aux_rvalid = 0.
  - starve_cnt = 0; force_aux = 0.
  - rom_addr = cpu_addr.
- Grant logic, evaluated each cycle, at most one grant:
  - force_aux = aux_req && (starve_cnt >= STARVE_LIMIT).
  - If force_aux: aux_gnt = 1.
  - Else if cpu_req: cpu_gnt = 1.
  - Else if aux_req: aux_gnt = 1.
  - Else no grant.
- rom_addr = aux_addr when aux_gnt, else cpu_addr. No grant still drives cpu_addr so the ROM read is harmless.
- Latency:
  - A grant in cycle N yields the port's rvalid = 1 in cycle N+1, with rdata = rom_data in N+1.
  - rvalid is a single-cycle registered copy of the grant.
  - Back-to-back grants give continuous rvalid.
- rdata outputs are a combinational pass-through of rom_data. They are meaningful only while the matching rvalid is high. Both ports see the same bus.
- starve_cnt (4-bit, saturating at 15), per clock:
  - Increments when aux_req = 1 and aux_gnt = 0.
  - Clears to 0 when aux_gnt = 1 or aux_req = 0.
- Forced aux grant while cpu_req = 1: cpu_gnt = 0. The CPU is stalled one cycle; the bus wrapper must hold RDY low when cpu_req && !cpu_gnt.
- Simultaneous aux_req drop and starve threshold: no force, because force requires aux_req.
- Writes are not arbitrated. The ROM is read-only; the bus decoder never raises cpu_req on a write.
- Reset asserted mid-transaction: pending rvalid is cleared immediately and no data is delivered. Requesters reissue after reset.
- Address wrap: offsets are taken modulo 2^ADDR_WIDTH, with no range check.

Test Plan:
- Reset with cpu_req = aux_req = 1 -> both gnt = 0 and both rvalid = 0. First cycle after rst_n rises: cpu_gnt = 1.
- CPU-only reads, cpu_addr = 0x0000 then 0x0003, back-to-back (ROM preloaded 0x0000 = 0x4C, 0x0003 = 0x20) -> cpu_rvalid high in cycles 1 and 2 with rdata 0x4C then 0x20; aux_rvalid = 0 throughout.
- aux_req only, aux_addr = 0x3FFC (ROM = 0x00) -> aux_gnt same cycle, rom_addr = 0x3FFC, aux_rvalid = 1 with 0x00 next cycle.
- cpu_req held continuously, aux_req held from cycle 0, STARVE_LIMIT = 4 -> cpu granted cycles 0-3, aux_gnt in cycle 4 (cpu_gnt = 0), starve_cnt back to 0, cpu granted again from cycle 5.
- aux_req withdrawn at starve_cnt = 3, then reasserted -> counter restarts from 0; no forced grant until 4 further denied cycles.
- Reset pulse in the cycle after a cpu_gnt -> cpu_rvalid never asserts for that read; starve_cnt = 0 after release.
